instr_mem_loadable: RTL



---
 rtl/instr_mem_pkg.sv | 20 ++
 rtl/byte_ram_w32.sv | 42 ++++
 rtl/instr_mem_loadable.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/instr_mem_pkg.sv
// Shared definitions for the loadable instruction memory.
// Contents:
//   state_t           controller state encoding (IDLE=0, LOAD=1, RUN=2)
//   NOP_INSTR         default substitute word, addi x0,x0,0
//   FAULT_MISALIGNED  bit index of the misaligned-fetch flag
//   FAULT_RANGE       bit index of the out-of-range flag
package instr_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int FAULT_MISALIGNED = 0;
  localparam int FAULT_RANGE      = 1;

endpackage

// File: rtl/byte_ram_w32.sv
// Byte-organised RAM with one aligned 32-bit write port and one registered
// 32-bit little-endian read port. Byte 0 of a word sits in data bits [7:0].
// Ports:
//   clk    rising-edge clock
//   we     write enable for the word at waddr
//   waddr  word index of the write
//   wdata  word to write
//   re     read enable; rdata updates only when set, otherwise it holds
//   raddr  word index of the read
//   rdata  registered read word
// The array has no reset so its contents survive a controller reset.
module byte_ram_w32 #(
  parameter int DEPTH_BYTES = 256,
  parameter int IW          = $clog2(DEPTH_BYTES / 4)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [IW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [7:0] mem [DEPTH_BYTES];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int k = 0; k < 4; k++) begin
        mem[{waddr, 2'(k)}] <= wdata[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= {mem[{raddr, 2'd3}], mem[{raddr, 2'd2}],
                mem[{raddr, 2'd1}], mem[{raddr, 2'd0}]};
    end
  end

endmodule

// File: rtl/instr_mem_loadable.sv
// Run-time loadable, byte-addressed instruction memory for the IF stage.
// A loader fills the memory word by word in LOAD, then RUN serves 1-cycle
// fetches with stall hold and misaligned/out-of-range fault reporting.
// Ports:
//   clk, reset_n       clock, synchronous active-low reset
//   load_start         enter LOAD, clear write pointer
//   load_valid         load_data valid this cycle
//   load_data          word to store, bits [7:0] at the lowest address
//   load_done          leave LOAD for RUN
//   load_ready         LOAD and pointer below DEPTH_BYTES
//   load_ptr           current byte write pointer
//   load_overflow      sticky: word offered with the memory full
//   fetch_req          fetch request at inst_address
//   stall              hold instruction/inst_valid/fault
//   inst_address       byte fetch address
//   instruction        fetched word (NOP_WORD on fault and after reset)
//   inst_valid         instruction holds a fetch result
//   fault              {out_of_range, misaligned}
//   state_o            IDLE=0, LOAD=1, RUN=2
module instr_mem_loadable
  import instr_mem_pkg::*;
#(
  parameter int          DEPTH_BYTES = 256,
  parameter int          ADDR_W      = 64,
  parameter logic [31:0] NOP_WORD    = NOP_INSTR
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           load_start,
  input  logic                           load_valid,
  input  logic [31:0]                    load_data,
  input  logic                           load_done,
  output logic                           load_ready,
  output logic [$clog2(DEPTH_BYTES):0]   load_ptr,
  output logic                           load_overflow,
  input  logic                           fetch_req,
  input  logic                           stall,
  input  logic [ADDR_W-1:0]              inst_address,
  output logic [31:0]                    instruction,
  output logic                           inst_valid,
  output logic [1:0]                     fault,
  output logic [1:0]                     state_o
);

  localparam int BW = $clog2(DEPTH_BYTES);
  localparam int PW = BW + 1;
  localparam int IW = BW - 2;

  state_t        state_q, state_d;
  logic [PW-1:0] ptr_q;
  logic          ovf_q;
  logic          valid_q;
  logic [1:0]    fault_q;
  logic          show_nop_q;

  logic          misaligned, out_of_range;
  logic          wr_en, fetch_take, ram_re;
  logic [31:0]   ram_rdata;

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // load_start restarts loading from any state and beats load_done.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (load_start) state_d = ST_LOAD;
      ST_LOAD: begin
        if (load_start)     state_d = ST_LOAD;
        else if (load_done) state_d = ST_RUN;
      end
      ST_RUN:  if (load_start) state_d = ST_LOAD;
      default: state_d = ST_IDLE;
    endcase
  end

  // Full-width compare so a huge address can never wrap into range.
  assign misaligned   = (inst_address[1:0] != 2'b00);
  assign out_of_range = (inst_address > ADDR_W'(DEPTH_BYTES - 4));

  assign load_ready = (state_q == ST_LOAD) && (ptr_q < PW'(DEPTH_BYTES));
  assign wr_en      = (state_q == ST_LOAD) && !load_start && load_valid && load_ready;
  assign fetch_take = (state_q == ST_RUN) && !load_start && fetch_req && !stall;
  // Faulting fetches never touch the array, which also keeps the index legal.
  assign ram_re     = fetch_take && !misaligned && !out_of_range;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (load_start)  ptr_q <= '0;
      else if (wr_en)  ptr_q <= ptr_q + PW'(4);
      if ((state_q == ST_LOAD) && !load_start && load_valid && !load_ready)
        ovf_q <= 1'b1;
    end
  end

  // The read data register only changes on a clean fetch, so holding on stall
  // or idle cycles falls out naturally; show_nop_q selects the substitute.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q    <= 1'b0;
      fault_q    <= 2'b00;
      show_nop_q <= 1'b1;
    end else if (load_start) begin
      valid_q <= 1'b0;
    end else if ((state_q == ST_RUN) && !stall) begin
      valid_q <= fetch_req;
      if (fetch_req) begin
        fault_q[FAULT_MISALIGNED] <= misaligned;
        fault_q[FAULT_RANGE]      <= out_of_range;
        show_nop_q                <= misaligned || out_of_range;
      end
    end
  end

  byte_ram_w32 #(
    .DEPTH_BYTES(DEPTH_BYTES),
    .IW         (IW)
  ) u_ram (
    .clk  (clk),
    .we   (wr_en),
    .waddr(ptr_q[BW-1:2]),
    .wdata(load_data),
    .re   (ram_re),
    .raddr(inst_address[BW-1:2]),
    .rdata(ram_rdata)
  );

  assign instruction   = show_nop_q ? NOP_WORD : ram_rdata;
  assign inst_valid    = valid_q;
  assign fault         = fault_q;
  assign load_ptr      = ptr_q;
  assign load_overflow = ovf_q;
  assign state_o       = state_q;

endmodule
